// File: rtl/decode_issue_stage.sv
// RV32I integer decode/issue stage: register file with writeback bypass, busy-bit
// RAW scoreboard, and a registered operand/ALUop output behind a valid/ready handshake.
module decode_issue_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] rs1,
  output logic [31:0] rs2,
  output logic [3:0]  ALUop,
  output logic [4:0]  out_rd,
  output logic        illegal,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data
);

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  localparam logic [3:0] ALU_ADD = 4'b1001;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b1101;

  logic [31:0] r_regs [32];
  logic [31:0] r_busy;
  logic        r_out_valid;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic [3:0]  r_aluop;
  logic [4:0]  r_out_rd;
  logic        r_illegal;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1_idx;
  logic [4:0]  w_rs2_idx;
  logic        w_legal;
  logic [3:0]  w_aluop;
  logic        w_use_imm;
  logic [31:0] w_imm;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic        w_rs1_clr;
  logic        w_rs2_clr;
  logic        w_hazard;
  logic        w_accept;

  assign w_opcode  = instr[6:0];
  assign w_rd      = instr[11:7];
  assign w_funct3  = instr[14:12];
  assign w_rs1_idx = instr[19:15];
  assign w_rs2_idx = instr[24:20];
  assign w_funct7  = instr[31:25];

  always_comb begin
    w_legal   = 1'b0;
    w_aluop   = 4'b0000;
    w_use_imm = 1'b0;
    w_imm     = 32'd0;
    case (w_opcode)
      OP_REG: begin
        case ({w_funct7, w_funct3})
          {7'b0000000, 3'b000}: begin w_legal = 1'b1; w_aluop = ALU_ADD; end
          {7'b0100000, 3'b000}: begin w_legal = 1'b1; w_aluop = ALU_SUB; end
          {7'b0000000, 3'b100}: begin w_legal = 1'b1; w_aluop = ALU_XOR; end
          {7'b0000000, 3'b110}: begin w_legal = 1'b1; w_aluop = ALU_OR;  end
          {7'b0000000, 3'b111}: begin w_legal = 1'b1; w_aluop = ALU_AND; end
          {7'b0000000, 3'b001}: begin w_legal = 1'b1; w_aluop = ALU_SLL; end
          {7'b0000000, 3'b101}: begin w_legal = 1'b1; w_aluop = ALU_SRL; end
          default: ;
        endcase
      end
      OP_IMM: begin
        w_use_imm = 1'b1;
        w_imm     = {{20{instr[31]}}, instr[31:20]};
        case (w_funct3)
          3'b000: begin w_legal = 1'b1; w_aluop = ALU_ADD; end
          3'b100: begin w_legal = 1'b1; w_aluop = ALU_XOR; end
          3'b110: begin w_legal = 1'b1; w_aluop = ALU_OR;  end
          3'b111: begin w_legal = 1'b1; w_aluop = ALU_AND; end
          3'b001: begin
            if (w_funct7 == 7'b0000000) begin
              w_legal = 1'b1;
              w_aluop = ALU_SLL;
              w_imm   = {27'd0, instr[24:20]};
            end
          end
          3'b101: begin
            if (w_funct7 == 7'b0000000) begin
              w_legal = 1'b1;
              w_aluop = ALU_SRL;
              w_imm   = {27'd0, instr[24:20]};
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // A writeback landing this cycle both feeds the operand and retires the hazard.
  assign w_rs1_clr = wb_en && (wb_rd == w_rs1_idx);
  assign w_rs2_clr = wb_en && (wb_rd == w_rs2_idx);

  assign w_rs1_val = (w_rs1_idx == 5'd0) ? 32'd0 :
                     w_rs1_clr           ? wb_data : r_regs[w_rs1_idx];
  assign w_rs2_val = (w_rs2_idx == 5'd0) ? 32'd0 :
                     w_rs2_clr           ? wb_data : r_regs[w_rs2_idx];

  assign w_hazard = (r_busy[w_rs1_idx] && !w_rs1_clr) ||
                    ((w_opcode == OP_REG) && r_busy[w_rs2_idx] && !w_rs2_clr);

  assign in_ready = !rst && in_valid && (!r_out_valid || out_ready) && !w_hazard;
  assign w_accept = in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else if (wb_en && (wb_rd != 5'd0)) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  // Set has priority over a same-cycle clear of the same index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 32'd0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (w_accept && w_legal && (w_rd == 5'(i))) r_busy[i] <= 1'b1;
        else if (wb_en && (wb_rd == 5'(i)))          r_busy[i] <= 1'b0;
      end
      r_busy[0] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_rs1       <= 32'd0;
      r_rs2       <= 32'd0;
      r_aluop     <= 4'b0000;
      r_out_rd    <= 5'd0;
      r_illegal   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_rs1       <= w_legal ? w_rs1_val : 32'd0;
      r_rs2       <= !w_legal ? 32'd0 : (w_use_imm ? w_imm : w_rs2_val);
      r_aluop     <= w_aluop;
      r_out_rd    <= w_legal ? w_rd : 5'd0;
      r_illegal   <= !w_legal;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign rs1       = r_rs1;
  assign rs2       = r_rs2;
  assign ALUop     = r_aluop;
  assign out_rd    = r_out_rd;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: directed scenarios plus a randomized run against a
// mnemonic-table reference model of the register file, scoreboard and output register.
`timescale 1ns/1ps
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, illegal, wb_en;
  logic [31:0] instr, rs1, rs2, wb_data;
  logic [3:0]  ALUop;
  logic [4:0]  out_rd, wb_rd;
  logic [74:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .rs1(rs1), .rs2(rs2), .ALUop(ALUop),
    .out_rd(out_rd), .illegal(illegal), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  assign obs = {out_valid, rs1, rs2, ALUop, out_rd, illegal};

  // Instruction table: mask/match per mnemonic, ALUop, operand-2 kind (0 reg, 1 simm12, 2 shamt).
  localparam logic [31:0] MASK [13] = '{
    32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
    32'hFE00707F, 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'hFE00707F,
    32'hFE00707F};
  localparam logic [31:0] MATCH [13] = '{
    32'h00000033, 32'h40000033, 32'h00004033, 32'h00006033, 32'h00007033, 32'h00001033,
    32'h00005033, 32'h00000013, 32'h00004013, 32'h00006013, 32'h00007013, 32'h00001013,
    32'h00005013};
  localparam logic [3:0] OPC [13] = '{
    4'h9, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hD, 4'h9, 4'h2, 4'h3, 4'h4, 4'h5, 4'hD};
  localparam int KIND [13] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2};

  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_ov = 1'b0;
  logic [31:0] m_rs1, m_rs2;
  logic [3:0]  m_op;
  logic [4:0]  m_rd;
  bit          m_ill;

  function automatic int m_find(input logic [31:0] w);
    for (int i = 0; i < 13; i++)
      if ((w & MASK[i]) == MATCH[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_en && wb_rd == idx) return wb_data;
    return m_regs[idx];
  endfunction

  function automatic bit m_ready();
    logic [4:0] a, b;
    a = instr[19:15];
    b = instr[24:20];
    if (rst || !in_valid) return 1'b0;
    if (m_ov && !out_ready) return 1'b0;
    if (m_busy[a] && !(wb_en && wb_rd == a)) return 1'b0;
    if (instr[6:0] == 7'h33 && m_busy[b] && !(wb_en && wb_rd == b)) return 1'b0;
    return 1'b1;
  endfunction

  // Advances the model by one cycle from the currently driven inputs, then the clock.
  task automatic tick();
    bit acc;
    int k;
    acc = m_ready();
    k = m_find(instr);
    if (rst) begin
      m_ov = 0; m_rs1 = 0; m_rs2 = 0; m_op = 0; m_rd = 0; m_ill = 0;
      for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_busy[i] = 0; end
    end else begin
      if (acc) begin
        m_ov = 1;
        if (k < 0) begin
          m_rs1 = 0; m_rs2 = 0; m_op = 0; m_rd = 0; m_ill = 1;
        end else begin
          m_rs1 = m_read(instr[19:15]);
          if (KIND[k] == 0)      m_rs2 = m_read(instr[24:20]);
          else if (KIND[k] == 1) m_rs2 = {{20{instr[31]}}, instr[31:20]};
          else                   m_rs2 = {27'd0, instr[24:20]};
          m_op = OPC[k]; m_rd = instr[11:7]; m_ill = 0;
        end
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (wb_en) m_busy[wb_rd] = 0;
      if (wb_en && wb_rd != 0) m_regs[wb_rd] = wb_data;
      if (acc && k >= 0 && instr[11:7] != 0) m_busy[instr[11:7]] = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; in_valid = 0; out_ready = 1; wb_en = 0; wb_rd = 0; wb_data = 0; instr = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] f;
    int k;
    k = $urandom_range(0, 15);
    f = (32'($urandom_range(0, 7)) << 20) | (32'($urandom_range(0, 7)) << 15) |
        (32'($urandom_range(0, 7)) << 7);
    if (k < 7)       return MATCH[k] | f;
    else if (k < 11) return MATCH[k] | (f & 32'h000FFFFF) | (32'($urandom_range(0, 4095)) << 20);
    else if (k < 13) return MATCH[k] | f;
    else if (k == 13) return $urandom;
    else if (k == 14) return 32'h40005033 | f;
    return 32'h40005013 | f;
  endfunction

  task automatic test_reset();
    idle();
    rst = 1; in_valid = 1; instr = 32'h002081B3;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    tick();
    idle();
    checks++;
    if (obs !== 75'd0) begin errors++; $display("FAIL reset_outputs: got %h want 0", obs); end
  endtask

  task automatic test_basic_rtype();
    logic [74:0] e;
    idle();
    wb_en = 1; wb_rd = 1; wb_data = 5; tick();
    wb_rd = 2; wb_data = 7; tick();
    wb_en = 0; in_valid = 1; instr = 32'h002081B3;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 0;
    e = {1'b1, 32'd5, 32'd7, 4'b1001, 5'd3, 1'b0};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL add_issue: got %h want %h", obs, e); end
    in_valid = 1; instr = 32'h00018433;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL busy3_stall: got %b want 0", in_ready); end
    instr = 32'h402082B3;
    tick();
    in_valid = 0;
    e = {1'b1, 32'd5, 32'd7, 4'b0001, 5'd5, 1'b0};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL sub_issue: got %h want %h", obs, e); end
    wb_en = 1; wb_rd = 3; wb_data = 32'd12; tick();
    wb_rd = 5; wb_data = 32'hFFFFFFFE; tick();
    wb_en = 0;
  endtask

  task automatic test_immediates();
    logic [74:0] e;
    idle();
    in_valid = 1; instr = 32'hFFF00213; tick();
    e = {1'b1, 32'd0, 32'hFFFFFFFF, 4'b1001, 5'd4, 1'b0};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL addi_neg: got %h want %h", obs, e); end
    instr = 32'h0030D313; tick();
    in_valid = 0;
    e = {1'b1, 32'd5, 32'd3, 4'b1101, 5'd6, 1'b0};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL srli: got %h want %h", obs, e); end
    wb_en = 1; wb_rd = 6; wb_data = 0; tick();
    wb_en = 0;
  endtask

  task automatic test_raw_stall();
    logic [74:0] e;
    idle();
    in_valid = 1; instr = 32'hFFF00213; tick();
    instr = 32'h004203B3;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_hold_%0d: got %b want 0", c, in_ready); end
      tick();
    end
    wb_en = 1; wb_rd = 4; wb_data = 32'hFFFFFFFF;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_release: got %b want 1", in_ready); end
    tick();
    wb_en = 0; in_valid = 0;
    e = {1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1001, 5'd7, 1'b0};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL raw_bypass: got %h want %h", obs, e); end
  endtask

  task automatic test_backpressure();
    logic [74:0] ea, e;
    idle();
    tick();
    in_valid = 1; instr = 32'h00108493; out_ready = 0; tick();
    ea = {1'b1, 32'd5, 32'd1, 4'b1001, 5'd9, 1'b0};
    checks++;
    if (obs !== ea) begin errors++; $display("FAIL bp_first: got %h want %h", obs, ea); end
    instr = 32'h0F00C513;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d: got %b want 0", c, in_ready); end
      tick();
      checks++;
      if (obs !== ea) begin errors++; $display("FAIL bp_stable_%0d: got %h want %h", c, obs, ea); end
    end
    out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_resume: got %b want 1", in_ready); end
    tick();
    e = {1'b1, 32'd5, 32'h000000F0, 4'b0010, 5'd10, 1'b0};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL bp_second: got %h want %h", obs, e); end
    instr = 32'h01016593; tick();
    in_valid = 0;
    e = {1'b1, 32'd7, 32'h00000010, 4'b0011, 5'd11, 1'b0};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL bp_third: got %h want %h", obs, e); end
    tick();
    e = {1'b0, 32'd7, 32'h00000010, 4'b0011, 5'd11, 1'b0};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL bp_drain: got %h want %h", obs, e); end
  endtask

  task automatic test_illegal_x0();
    logic [74:0] e;
    idle();
    e = {1'b1, 32'd0, 32'd0, 4'b0000, 5'd0, 1'b1};
    in_valid = 1; instr = 32'h0000007F; tick();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL illegal_7f: got %h want %h", obs, e); end
    instr = 32'h000006FF; tick();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL illegal_rd13: got %h want %h", obs, e); end
    instr = 32'h00D68733;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL illegal_no_busy: got %b want 1", in_ready); end
    tick();
    wb_en = 1; wb_rd = 0; wb_data = 32'h12345678; instr = 32'h000007B3; tick();
    e = {1'b1, 32'd0, 32'd0, 4'b1001, 5'd15, 1'b0};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL x0_bypass: got %h want %h", obs, e); end
    wb_en = 0; tick();
    in_valid = 0;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL x0_array: got %h want %h", obs, e); end
  endtask

  task automatic test_mid_reset();
    logic [74:0] e;
    idle();
    tick();
    in_valid = 1; instr = 32'h002081B3; out_ready = 0; tick();
    in_valid = 0;
    e = {1'b1, 32'd5, 32'd7, 4'b1001, 5'd3, 1'b0};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL mr_pre: got %h want %h", obs, e); end
    rst = 1; wb_en = 1; wb_rd = 1; wb_data = 32'h0000DEAD; tick();
    rst = 0; wb_en = 0;
    checks++;
    if (obs !== 75'd0) begin errors++; $display("FAIL mr_cleared: got %h want 0", obs); end
    out_ready = 1; in_valid = 1; instr = 32'h003181B3;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mr_busy_clear: got %b want 1", in_ready); end
    tick();
    e = {1'b1, 32'd0, 32'd0, 4'b1001, 5'd3, 1'b0};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL mr_add_x3: got %h want %h", obs, e); end
    instr = 32'h00108833; tick();
    in_valid = 0;
    e = {1'b1, 32'd0, 32'd0, 4'b1001, 5'd16, 1'b0};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL mr_wb_dropped: got %h want %h", obs, e); end
  endtask

  task automatic test_random();
    logic [74:0] e;
    bit exp_rdy;
    for (int n = 0; n < 500; n++) begin
      rst       = ($urandom_range(0, 49) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      wb_en     = ($urandom_range(0, 9) < 4);
      wb_rd     = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      instr     = rand_instr();
      #1;
      exp_rdy = m_ready();
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL rand_ready_%0d: got %b want %b instr %h", n, in_ready, exp_rdy, instr);
      end
      tick();
      e = {m_ov, m_rs1, m_rs2, m_op, m_rd, m_ill};
      checks++;
      if (obs !== e) begin errors++; $display("FAIL rand_out_%0d: got %h want %h", n, obs, e); end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_basic_rtype();
    test_immediates();
    test_raw_stall();
    test_backpressure();
    test_illegal_x0();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_issue_stage.md
# decode_issue_stage

Decode/issue stage directly upstream of the ALU. It accepts 32-bit RV32I integer instruction words over a valid/ready handshake and reads a 32×32 register file. It stalls on read-after-write hazards using a busy-bit scoreboard, and registers the operand values and 4-bit ALU opcode that drive the ALU's `rs1`/`rs2`/`ALUop` inputs. Writeback enters through a dedicated write port, with same-cycle bypass to the read path.

## Interface
- No parameters; data width fixed at 32, register count fixed at 32.
- `clk` in 1 — single clock, all state updates on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `in_valid` in 1 — `instr` is valid.
- `in_ready` out 1 — stage accepts `instr` this cycle (combinational).
- `instr` in 32 — RV32I instruction word.
- `out_valid` out 1 — output register holds an issued instruction.
- `out_ready` in 1 — downstream consumes the output register this cycle.
- `rs1` out 32 — first operand value; connects to ALU `rs1`.
- `rs2` out 32 — second operand value or immediate; connects to ALU `rs2`.
- `ALUop` out 4 — ALU opcode; connects to ALU `ALUop`.
- `out_rd` out 5 — destination register of the issued instruction.
- `illegal` out 1 — issued word was not a supported instruction.
- `wb_en` in 1 — writeback strobe.
- `wb_rd` in 5 — writeback register index.
- `wb_data` in 32 — writeback value.

## Operation
- **Decode, opcode 0110011 (R-type), funct7/funct3 → ALUop:**
  - ADD: 0000000/000 → 1001
  - SUB: 0100000/000 → 0001
  - XOR: 0000000/100 → 0010
  - OR: 0000000/110 → 0011
  - AND: 0000000/111 → 0100
  - SLL: 0000000/001 → 0101
  - SRL: 0000000/101 → 1101
- **Decode, opcode 0010011 (I-type):**
  - ADDI/XORI/ORI/ANDI (funct3 000/100/110/111) use the same ALUop as the R-type form; `rs2` = sign-extended `instr[31:20]`.
  - SLLI (funct3 001, `instr[31:25]`=0000000) → ALUop 0101; SRLI (funct3 101, `instr[31:25]`=0000000) → ALUop 1101. For both, `rs2` = zero-extended `instr[24:20]`.
- **Unsupported words:** any other opcode/funct combination issues with ALUop 0000, `illegal`=1, `out_rd`=0, `rs1`=`rs2`=0. Unsupported words never set a busy bit.
- **Register file:**
  - x0 always reads 0; writes to x0 are ignored.
  - Write occurs when `wb_en` and `wb_rd`≠0.
  - Read bypass: if `wb_en` and `wb_rd`==src and src≠0, the read returns `wb_data`.
- **Scoreboard (32 busy bits, bit 0 hard-wired 0):**
  - Set `busy[rd]` when a legal instruction with rd≠0 is accepted.
  - Clear `busy[wb_rd]` on `wb_en`.
  - If a set and a clear target the same index in the same cycle, set wins.
- **Hazard:**
  - Asserted if `busy[rs1 field]` is set, or (R-type only) `busy[rs2 field]` is set.
  - A busy bit being cleared by `wb_en` in the same cycle does not count as a hazard; that operand is taken from the bypass.
  - WAW is not checked.
- **Handshake:**
  - `in_ready` = !`rst` && (!`out_valid` || `out_ready`) && !hazard. `in_ready` is 0 when `in_valid`=0 and the hazard is evaluated on the current `instr`.
  - Accept = `in_valid` && `in_ready`; on accept, the output register loads the decoded fields and `out_valid`←1.
  - Else if `out_ready`, `out_valid`←0 and the data fields hold their values.
  - While `out_valid` && !`out_ready`, all outputs hold stable.

## Timing
- **Reset** (synchronous, sampled at clock edge):
  - `out_valid`=0, `rs1`=`rs2`=0, `ALUop`=0000, `out_rd`=0, `illegal`=0.
  - All busy bits = 0; all 32 registers = 0.
- **Mid-operation reset:** an in-flight output is dropped, and any `wb_en` in the reset cycle is ignored.
- **Latency:**
  - Accept at edge N → outputs valid after edge N.
  - The ALU samples at edge N+1, so its result is available after edge N+1.
- **Throughput:** 1 instruction/cycle when `out_ready`=1 and there are no hazards.
- **Writeback timing:** a write at edge N is visible to a decode in cycle N via bypass and from the array after edge N.
- **Stall release:** the busy bit clears at the same edge as the data write.

## Test plan
- **Basic R-type issue.** Write x1=5 and x2=7 via writeback, then send `instr`=0x002081B3 (add x3,x1,x2) with `out_ready`=1.
  - Required: next cycle `out_valid`=1, `rs1`=5, `rs2`=7, `ALUop`=1001, `out_rd`=3, busy[3]=1.
  - Send 0x402082B3 (sub x5,x1,x2). Required: `ALUop`=0001, `out_rd`=5.
- **Immediates.**
  - 0xFFF00213 (addi x4,x0,-1) → `rs1`=0, `rs2`=0xFFFFFFFF, `ALUop`=1001.
  - 0x0030D313 (srli x6,x1,3) with x1=5 → `rs1`=5, `rs2`=3, `ALUop`=1101.
- **RAW stall with bypass release.** Issue 0xFFF00213, then hold 0x004203B3 (add x7,x4,x4).
  - Required: `in_ready`=0 until the cycle with `wb_en`=1, `wb_rd`=4, `wb_data`=0xFFFFFFFF.
  - In that cycle the instruction is accepted; next cycle `rs1`=`rs2`=0xFFFFFFFF.
- **Backpressure.** Hold `out_ready`=0 with `out_valid`=1 and two instructions queued at the input.
  - Required: outputs stable and `in_ready`=0.
  - After `out_ready`=1, the next instruction loads in that same cycle, with no loss or duplication.
- **Illegal instruction and x0.**
  - Send 0x0000007F. Required: `illegal`=1, `ALUop`=0000, no busy bit set.
  - Write with `wb_rd`=0, `wb_data`=0x12345678. Required: a later read of x0 returns 0.
- **Reset mid-operation.** Assert `rst` for one cycle while `out_valid`=1 and busy[3]=1.
  - Required: `out_valid`=0, all outputs 0, busy cleared.
  - A following add x3,x3,x3 is accepted immediately with `rs1`=`rs2`=0.
